bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential double-dabble converter between the 8-bit ripple-carry adder stage and the seg7 display decoders. It takes the adder's 9-bit result ({carry-out, sum}) on a start pulse and produces three packed BCD digits. The digits drive seg7 instances so the sum shows in decimal on HEX2..HEX0. It shifts one bit per clock under a small FSM with a start/busy/done handshake.

## Interface
- WIDTH, 9: binary input width, {cout, S[7:0]}.
- DIGITS, 3: BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1; elaboration fails otherwise.
- clock  in  1  single clock, all state updates on its rising edge.
- Resetn  in  1  reset, synchronous, active-low.
- start  in  1  request a conversion; sampled only when busy=0.
- bin  in  WIDTH  unsigned value to convert; sampled with start.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse: bcd just updated.
- bcd  out  4*DIGITS  packed digits; bcd[3:0] = ones, bcd[7:4] = tens, bcd[11:8] = hundreds.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On start=1: load bin into shift register, clear scratch digits, set bit counter to WIDTH, go to SHIFT.
- SHIFT, once per cycle:
  - Every scratch digit ≥5 gets +3 (4-bit, no carry out of the digit).
  - Then {scratch, shift} shift left by 1; the shift register MSB enters the ones-digit LSB.
  - Counter decrements.
  - When the counter goes 1→0, copy the post-shift scratch into the bcd output register and go to DONE.
- DONE:
  - done=1, busy=0.
  - start=1 here is accepted exactly as in IDLE (back-to-back); otherwise go to IDLE.
- start while in SHIFT is ignored; bin changes during SHIFT have no effect.
- bcd changes only at the completion edge. It holds the last result indefinitely, including during a later conversion.
- Reset (Resetn=0 at an edge) in any state:
  - state=IDLE, busy=0, done=0, bcd=0, scratch and counter cleared.
  - An in-flight conversion is discarded. No done pulse is produced for it.
- Arithmetic: all digit adjusts are 4-bit and unsigned. Scratch width is 4*DIGITS. No overflow is possible under the parameter rule.

## Timing
- Edge E0 samples start=1 in IDLE/DONE. busy=1 from E0 until E(WIDTH).
- Shifts occur on E1..E(WIDTH).
- After E(WIDTH): bcd is valid, done=1 for exactly one cycle, busy=0.
- Start-to-done latency is WIDTH cycles (9 with defaults). Throughput is one conversion per WIDTH+1 cycles when start is held or re-pulsed in DONE.
- All outputs are registered; no combinational path from start/bin to any output.
- Resetn takes effect only at a rising clock edge.

## Structure
- A shared package holds the state enum (IDLE, SHIFT, DONE), the default WIDTH/DIGITS constants, and the digit width constant 4.
- One sub-module, bcd_adj3: combinational 4-bit "if ≥5 add 3" cell, instantiated DIGITS times per shift step.
- Top level contains the FSM, counter, shift/scratch registers and the output register. Output digits feed existing seg7 instances unchanged.

## Test plan
- Reset: hold Resetn=0 for 2 edges → busy=0, done=0, bcd=0x000; release, no start → outputs stay 0.
- Max value: bin=9'h1FF, start pulse → busy high 9 cycles, done pulses on cycle 9, bcd=0x511.
- Sum without carry: bin=9'd255 → bcd=0x255 after 9 cycles. Then bin=0 → bcd=0x000, and the done pulse still occurs.
- Ignored start: start bin=9'd100; pulse start with bin=9'd7 at cycle 4 → result bcd=0x100, single done pulse.
- Back-to-back: bin=9'd42 start, hold start=1 with bin=9'd399 through DONE → first done gives 0x042, second done 10 cycles later gives 0x399.
- Reset mid-operation: start bin=9'd321, drop Resetn at cycle 5 → no done, bcd stays previous value cleared to 0x000, busy=0. A new start then gives correct 0x321.

Source files
------------

// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned DEFAULT_WIDTH  = 9;
  localparam int unsigned DEFAULT_DIGITS = 3;
  localparam int unsigned DIGIT_W        = 4;

  // Used at elaboration to confirm the digit count covers the largest input.
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble digit correction: add 3 when the digit is 5 or more.
module bcd_adj3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  always_comb begin
    dout = din;
    if (din >= 4'd5) begin
      dout = din + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, start/busy/done handshake,
// result held in a registered bcd output between conversions.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = DEFAULT_WIDTH,
  parameter int unsigned DIGITS = DEFAULT_DIGITS
) (
  input  logic                    clock,
  input  logic                    Resetn,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcd
);

  localparam int unsigned SW = DIGIT_W * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_params
    $error("bin2bcd_seq: DIGITS too small for WIDTH");
  end

  state_e           state_q;
  logic [WIDTH-1:0] shift_q;
  logic [SW-1:0]    scratch_q;
  logic [SW-1:0]    scratch_adj;
  logic [SW-1:0]    scratch_shf;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    bcd_q;
  logic             busy_q;
  logic             done_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_adj3 u_adj (
      .din  (scratch_q[g*DIGIT_W +: DIGIT_W]),
      .dout (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Adjusted digits shift left; the binary MSB enters the ones digit.
  assign scratch_shf = {scratch_adj[SW-2:0], shift_q[WIDTH-1]};

  always_ff @(posedge clock) begin
    if (!Resetn) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      bcd_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            shift_q   <= bin;
            scratch_q <= '0;
            cnt_q     <= CW'(WIDTH);
            busy_q    <= 1'b1;
            state_q   <= StShift;
          end else begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        StShift: begin
          scratch_q <= scratch_shf;
          shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
          cnt_q     <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            bcd_q   <= scratch_shf;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table plus handshake corner sequences,
// with a queue of expected results popped on every done pulse.
module tb_bin2bcd_seq;

  localparam int unsigned W = 9;

  logic         clock;
  logic         Resetn;
  logic         start;
  logic [W-1:0] bin;
  logic         busy;
  logic         done;
  logic [11:0]  bcd;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;
  int pushed    = 0;
  logic [11:0] exp_q[$];

  typedef struct {
    logic [W-1:0] bin;
    logic [11:0]  exp;
  } vec_t;

  vec_t vecs[10];

  bin2bcd_seq #(
    .WIDTH  (9),
    .DIGITS (3)
  ) dut (
    .clock  (clock),
    .Resetn (Resetn),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .bcd    (bcd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(posedge clock) begin
    #1;
    if (done === 1'b1) begin
      done_seen++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(bcd), 32'hFFFF_FFFF);
      end else begin
        check("bcd_result", 32'(bcd), 32'(exp_q.pop_front()));
      end
    end
  end

  // One conversion from IDLE/DONE; checks busy length, latency and bcd hold.
  task automatic run_conv(input logic [W-1:0] v, input logic [11:0] e);
    int n;
    int bc;
    logic [11:0] prev;
    start = 1'b1;
    bin   = v;
    exp_q.push_back(e);
    pushed++;
    tick();
    start = 1'b0;
    bin   = '0;
    prev  = bcd;
    bc    = busy ? 1 : 0;
    n     = 0;
    while (n < W + 6) begin
      if (n == W - 1) check("bcd_hold", 32'(bcd), 32'(prev));
      tick();
      n++;
      if (done === 1'b1) break;
      if (busy) bc++;
    end
    check("latency", n, W);
    check("busy_cycles", bc, W);
    check("busy_at_done", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int dcount;
    vecs[0] = '{9'h1FF, 12'h511};
    vecs[1] = '{9'd255, 12'h255};
    vecs[2] = '{9'd0,   12'h000};
    vecs[3] = '{9'd1,   12'h001};
    vecs[4] = '{9'd9,   12'h009};
    vecs[5] = '{9'd10,  12'h010};
    vecs[6] = '{9'd99,  12'h099};
    vecs[7] = '{9'd256, 12'h256};
    vecs[8] = '{9'd500, 12'h500};
    vecs[9] = '{9'd385, 12'h385};

    Resetn = 1'b0;
    start  = 1'b0;
    bin    = '0;
    tick();
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'h000);
    Resetn = 1'b1;
    repeat (3) tick();
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_bcd", 32'(bcd), 32'h000);

    foreach (vecs[i]) begin
      run_conv(vecs[i].bin, vecs[i].exp);
      tick();
    end

    for (int i = 0; i < 4; i++) begin
      int r;
      r = int'($urandom_range(0, 511));
      run_conv(W'(r), to_bcd(r));
      tick();
    end

    // Start while shifting is ignored: only one result, for the first value.
    start = 1'b1;
    bin   = 9'd100;
    exp_q.push_back(12'h100);
    pushed++;
    tick();
    start = 1'b0;
    bin   = 9'd0;
    repeat (3) tick();
    start = 1'b1;
    bin   = 9'd7;
    tick();
    start = 1'b0;
    bin   = 9'd0;
    dcount = 0;
    repeat (W + 6) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    check("ignored_start_dones", dcount, 1);
    check("ignored_start_bcd", 32'(bcd), 32'h100);
    check("ignored_start_busy", 32'(busy), 32'd0);

    // Back-to-back: start held through DONE launches the next conversion.
    start = 1'b1;
    bin   = 9'd42;
    exp_q.push_back(12'h042);
    pushed++;
    tick();
    bin = 9'd399;
    n = 0;
    while (n < W + 6) begin
      tick();
      n++;
      if (done === 1'b1) break;
    end
    check("b2b_first_latency", n, W);
    check("b2b_first_bcd", 32'(bcd), 32'h042);
    exp_q.push_back(12'h399);
    pushed++;
    tick();
    start = 1'b0;
    check("b2b_busy_again", 32'(busy), 32'd1);
    n = 1;
    while (n < W + 8) begin
      tick();
      n++;
      if (done === 1'b1) break;
    end
    check("b2b_done_spacing", n, W + 1);
    check("b2b_second_bcd", 32'(bcd), 32'h399);
    tick();

    // Reset mid-conversion discards it and clears the held result.
    start = 1'b1;
    bin   = 9'd321;
    tick();
    start = 1'b0;
    repeat (4) tick();
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'h000);
    dcount = 0;
    repeat (W + 4) begin
      tick();
      if (done === 1'b1) dcount++;
    end
    check("midrst_no_done", dcount, 0);
    run_conv(9'd321, 12'h321);
    tick();

    check("done_count", done_seen, pushed);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
